// File: rtl/controller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg : shared types and constants for the controller port blocks
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } port_state_t;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam logic [3:0] NES_ORDER [8] = '{4'd8, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

  localparam logic [4:0]  NES_LEN  = 5'd8;
  localparam logic [4:0]  SNES_LEN = 5'd16;
  localparam logic [11:0] BTN_OFF  = 12'hFFF;

  // Serial bit presented at frame position idx; positions past the word read as released.
  function automatic logic frame_bit(input logic [11:0] word, input logic snes,
                                     input logic [4:0] idx);
    logic b;
    b = 1'b1;
    if (snes) begin
      if (idx < 5'd12) b = word[idx[3:0]];
    end else if (idx < 5'd8) begin
      b = word[NES_ORDER[idx[2:0]]];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect : multi-flop synchronizer with rise/fall detection
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_sig,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_hist;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!reset_n) r_chain <= '0;
        else          r_chain <= async_sig;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (!reset_n) r_chain <= '0;
        else          r_chain <= {r_chain[SYNC_STAGES-2:0], async_sig};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) r_hist <= 1'b0;
    else          r_hist <= sync;
  end

  assign sync = r_chain[SYNC_STAGES-1];
  assign rise = sync & ~r_hist;
  assign fall = ~sync & r_hist;

endmodule

`default_nettype wire

// File: rtl/console_port_responder.sv
// ---------------------------------------------------------------------------
// console_port_responder : emulates a pad shift register on one console port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module console_port_responder
  import controller_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd12000,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [11:0] buttons_in,
  input  logic        mode_in,
  input  logic        latch_in,
  input  logic        pclk_in,
  output logic        data_out,
  output logic        busy_out,
  output logic        frame_done_out
);

  logic w_latch_sync, w_latch_rise, w_latch_fall;
  logic w_pclk_sync, w_pclk_rise, w_pclk_fall;
  logic w_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk       (clk_in),
    .reset_n   (reset_in),
    .async_sig (latch_in),
    .sync      (w_latch_sync),
    .rise      (w_latch_rise),
    .fall      (w_latch_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pclk_sync (
    .clk       (clk_in),
    .reset_n   (reset_in),
    .async_sig (pclk_in),
    .sync      (w_pclk_sync),
    .rise      (w_pclk_rise),
    .fall      (w_pclk_fall)
  );

  assign w_unused = &{1'b0, w_pclk_sync, w_pclk_fall};

  port_state_t r_state;
  logic [11:0] r_shadow;
  logic        r_snes;
  logic [4:0]  r_index;
  logic [15:0] r_timeout;
  logic        r_data;
  logic        r_busy;
  logic        r_done;

  logic [4:0] w_len;
  logic [4:0] w_next_index;

  assign w_len        = r_snes ? SNES_LEN : NES_LEN;
  assign w_next_index = r_index + 5'd1;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_state   <= IDLE;
      r_shadow  <= BTN_OFF;
      r_snes    <= 1'b0;
      r_index   <= 5'd0;
      r_timeout <= 16'd0;
      r_data    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A latch rise restarts the port from any state, abandoning any frame.
      if (w_latch_rise) begin
        r_state   <= LATCH;
        r_shadow  <= buttons_in;
        r_snes    <= mode_in;
        r_index   <= 5'd0;
        r_timeout <= 16'd0;
        r_data    <= frame_bit(buttons_in, mode_in, 5'd0);
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          LATCH: begin
            if (w_latch_fall) begin
              r_state   <= SHIFT;
              r_index   <= 5'd0;
              r_timeout <= 16'd0;
            end else if (w_latch_sync) begin
              r_shadow <= buttons_in;
              r_snes   <= mode_in;
              r_data   <= frame_bit(buttons_in, mode_in, 5'd0);
            end
          end
          SHIFT: begin
            if (w_pclk_rise) begin
              r_timeout <= 16'd0;
              if (w_next_index == w_len) begin
                r_state <= DONE;
                r_index <= w_len;
                r_data  <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_index <= w_next_index;
                r_data  <= frame_bit(r_shadow, r_snes, w_next_index);
              end
            end else if (r_timeout == TIMEOUT_CYCLES - 16'd1) begin
              // Console stopped clocking: drop the frame silently.
              r_state   <= IDLE;
              r_timeout <= 16'd0;
              r_data    <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_timeout <= r_timeout + 16'd1;
            end
          end
          default: begin
            r_data <= 1'b1;
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out       = r_data;
  assign busy_out       = r_busy;
  assign frame_done_out = r_done;

endmodule

`default_nettype wire

// File: tb/tb_console_port_responder.sv
// ---------------------------------------------------------------------------
// tb_console_port_responder : randomized scoreboard bench for the port responder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_console_port_responder;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [11:0] buttons_in;
  logic        mode_in;
  logic        latch_in;
  logic        pclk_in;
  logic        data_out;
  logic        busy_out;
  logic        frame_done_out;

  console_port_responder dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .buttons_in     (buttons_in),
    .mode_in        (mode_in),
    .latch_in       (latch_in),
    .pclk_in        (pclk_in),
    .data_out       (data_out),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int exp_done = 0;
  bit exp_q[$];

  // Reference model state: latched word, frame type, rises seen, frame live.
  logic [11:0] m_word;
  bit          m_snes;
  int          m_rises;
  bit          m_active;

  // NES serial order by button: A, B, Select, Start, Up, Down, Left, Right.
  int nes_map[8] = '{8, 0, 2, 3, 4, 5, 6, 7};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_bit(input logic [11:0] w, input bit snes, input int k);
    logic [11:0] t;
    int len;
    len = snes ? 16 : 8;
    if (k >= len) return 1'b1;
    if (snes) begin
      if (k >= 12) return 1'b1;
      t = w >> k;
    end else begin
      t = w >> nes_map[k];
    end
    return t[0];
  endfunction

  initial begin
    forever begin
      @(posedge pclk_in);
      if (exp_q.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("data_bit", int'(data_out), int'(e));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (frame_done_out) done_count++;
    end
  end

  task automatic do_latch(input logic [11:0] w, input bit snes);
    buttons_in = w;
    mode_in    = snes;
    latch_in   = 1'b1;
    repeat (6) @(negedge clk_in);
    latch_in = 1'b0;
    repeat (6) @(negedge clk_in);
    m_word   = w;
    m_snes   = snes;
    m_rises  = 0;
    m_active = 1'b1;
  endtask

  task automatic do_rise();
    int len;
    len = m_snes ? 16 : 8;
    if (m_active) begin
      exp_q.push_back(model_bit(m_word, m_snes, m_rises));
      if (m_rises == len - 1) exp_done++;
      m_rises++;
    end else begin
      exp_q.push_back(1'b1);
    end
    pclk_in = 1'b1;
    repeat (4) @(negedge clk_in);
    pclk_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    int n;
    int len;
    logic [11:0] w;
    bit s;
    reset_in   = 1'b0;
    buttons_in = 12'hFFF;
    mode_in    = 1'b0;
    latch_in   = 1'b0;
    pclk_in    = 1'b0;
    m_active   = 1'b0;
    m_word     = 12'hFFF;
    m_snes     = 1'b0;
    m_rises    = 0;
    repeat (3) @(negedge clk_in);
    check("reset_data", int'(data_out), 1);
    check("reset_busy", int'(busy_out), 0);
    check("reset_done", int'(frame_done_out), 0);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // SNES with B and R pressed
    do_latch(12'h7FE, 1'b1);
    check("snes_busy", int'(busy_out), 1);
    for (int i = 0; i < 16; i++) do_rise();
    check("snes_done", done_count, exp_done);
    check("snes_busy_end", int'(busy_out), 0);
    check("snes_data_end", int'(data_out), 1);

    // NES with A pressed, plus two extra clocks
    do_latch(12'hEFF, 1'b0);
    for (int i = 0; i < 8; i++) do_rise();
    check("nes_busy_end", int'(busy_out), 0);
    for (int i = 0; i < 2; i++) do_rise();
    check("nes_done", done_count, exp_done);

    // Shadow frozen after latch fall
    do_latch(12'hFFF, 1'b1);
    buttons_in = 12'h000;
    mode_in    = 1'b0;
    for (int i = 0; i < 16; i++) do_rise();
    check("frozen_done", done_count, exp_done);

    // Re-latch mid-frame
    do_latch(12'h0F0, 1'b1);
    for (int i = 0; i < 5; i++) do_rise();
    do_latch(12'hA5C, 1'b1);
    check("relatch_busy", int'(busy_out), 1);
    check("relatch_no_done", done_count, exp_done);
    for (int i = 0; i < 16; i++) do_rise();
    check("relatch_done", done_count, exp_done);

    // Timeout after three clocks
    do_latch(12'h123, 1'b1);
    for (int i = 0; i < 3; i++) do_rise();
    repeat (6000) @(negedge clk_in);
    check("timeout_busy_mid", int'(busy_out), 1);
    repeat (6200) @(negedge clk_in);
    m_active = 1'b0;
    check("timeout_busy", int'(busy_out), 0);
    check("timeout_data", int'(data_out), 1);
    check("timeout_no_done", done_count, exp_done);
    for (int i = 0; i < 2; i++) do_rise();

    // Reset mid-SHIFT
    do_latch(12'h000, 1'b1);
    for (int i = 0; i < 5; i++) do_rise();
    check("pre_reset_data", int'(data_out), 0);
    reset_in = 1'b0;
    @(negedge clk_in);
    check("midreset_data", int'(data_out), 1);
    check("midreset_busy", int'(busy_out), 0);
    check("midreset_done", int'(frame_done_out), 0);
    reset_in = 1'b1;
    m_active = 1'b0;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 4; i++) do_rise();
    check("postreset_done", done_count, exp_done);

    // Randomized frames with live input churn during shifting
    for (int f = 0; f < 30; f++) begin
      w = 12'($urandom);
      s = 1'($urandom);
      do_latch(w, s);
      len = s ? 16 : 8;
      n = $urandom_range(0, 20);
      for (int r = 0; r < n; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          buttons_in = 12'($urandom);
          mode_in    = 1'($urandom);
        end
        do_rise();
      end
      check("rand_done", done_count, exp_done);
      check("rand_busy", int'(busy_out), (n < len) ? 1 : 0);
    end

    repeat (4) @(negedge clk_in);
    check("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/console_port_responder.md
Name: console_port_responder

Overview:
- Console-side endpoint for one NES or SNES controller port.
- Takes one 12-bit active-low button word, which is one of the NES0/NES1/SNES0/SNES1 words from the controller select block, and answers the console's latch/clock polling on the serial data line.
- Emulates the parallel-load shift register inside a stock pad.
- Four instances are used, one per console port.

Parameters:
- TIMEOUT_CYCLES, 16'd12000: clk_in cycles with no pclk rise in SHIFT before the frame is abandoned (1 ms at 12 MHz).
- SYNC_STAGES, 2: synchronizer flops on latch_in and pclk_in.

Ports:
- clk_in, input, 1: system clock.
- reset_in, input, 1: reset, synchronous and active-low.
- buttons_in, input, 12: button word, active-low (1 = released, all-ones = off). Bit order is B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R (bit0 to bit11).
- mode_in, input, 1: 0 = NES, 8-bit frame; 1 = SNES, 16-bit frame. Sampled only while latched.
- latch_in, input, 1: console latch, asynchronous.
- pclk_in, input, 1: console data clock, asynchronous. Console samples data on falling edge; the pad shifts on rising edge.
- data_out, output, 1: serial data to console, active-low button level.
- busy_out, output, 1: high in LATCH or SHIFT.
- frame_done_out, output, 1: one-cycle pulse when the last bit of a frame is shifted past.

Behaviour:
- Reset (reset_in = 0 at a clk_in edge): state IDLE, data_out = 1, busy_out = 0, frame_done_out = 0, bit index = 0, shadow = 12'hFFF, timeout counter = 0, synchronizers and edge registers = 0.
- Synchronization:
  - latch_in and pclk_in each pass through SYNC_STAGES flops plus one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - All outputs are registered. With default SYNC_STAGES, an input transition reaches data_out on the 3rd clk_in rising edge.
- States: IDLE, LATCH, SHIFT, DONE.
- Any state, latch rise: go to LATCH. This aborts any frame in progress; no frame_done pulse.
- LATCH (every cycle while latch is high):
  - shadow <= buttons_in; frame length <= 8 if mode_in = 0, else 16.
  - data_out <= frame bit 0 of the live buttons_in.
  - pclk rises are ignored.
- LATCH, latch fall: go to SHIFT with index = 0. data_out holds frame bit 0 of the shadow.
- Frame bit order:
  - SNES: word bits 0..11, then indices 12..15 all output 1.
  - NES: A, B, Select, Start, Up, Down, Left, Right, i.e. word bits 8, 0, 2, 3, 4, 5, 6, 7.
- SHIFT:
  - Each pclk rise: index++, data_out <= frame bit[index+1], timeout counter cleared.
  - When index+1 = frame length: go to DONE, data_out <= 1, frame_done_out = 1 for exactly that cycle.
  - buttons_in changes do not affect the frame; the shadow is frozen.
- SHIFT timeout: the counter increments every cycle without a pclk rise. When it reaches TIMEOUT_CYCLES-1, go to IDLE with data_out <= 1 and no frame_done pulse.
- DONE: data_out = 1; further pclk rises are ignored; leave only on latch rise or reset.
- IDLE: data_out = 1.
- Simultaneous latch rise and pclk rise in the same cycle: latch wins.
- mode_in changes outside LATCH have no effect on the current frame.
- Index counter is 5 bits and never wraps; it saturates at the frame length.

Decomposition:
- Shared package controller_pkg holds:
  - state enum port_state_t (IDLE, LATCH, SHIFT, DONE);
  - button index localparams BTN_B..BTN_R (0..11);
  - NES_ORDER constant array {8,0,2,3,4,5,6,7};
  - NES_LEN = 8, SNES_LEN = 16;
  - BTN_OFF = 12'hFFF.
- One sub-module, sync_edge_detect: parameterized synchronizer producing sync/rise/fall. Instantiated twice.

Test Plan:
- SNES, B and R pressed (buttons_in = 12'h7FE), latch pulse, then 16 pclk pulses.
  - Sampled bits: 0,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1.
  - frame_done_out pulses once after the 16th rise; data_out = 1 afterwards.
- NES, A only pressed (12'hEFF).
  - Sampled bits: 0,1,1,1,1,1,1,1; a 9th and 10th pclk both read 1.
  - busy_out falls after the 8th rise.
- Latch, then change buttons_in to 12'h000 after the latch fall.
  - All 16 SNES bits still reflect the latched value (12'hFFF, so all 1s).
- Latch re-asserted after 5 pclk rises.
  - State returns to LATCH, no frame_done pulse.
  - The new frame restarts at bit 0 with fresh buttons.
- Latch, 3 pclk rises, then no clocks for TIMEOUT_CYCLES.
  - Return to IDLE, data_out = 1, busy_out = 0, no frame_done pulse.
- Assert reset_in = 0 mid-SHIFT for one cycle.
  - All outputs reach reset values at the next edge.
  - Subsequent pclk rises without a latch leave data_out = 1.
